// File: rtl/multiflop_f.sv
// Three flavours of plain D-flop banks sharing one clock and one async reset:
// independent flops (F1), a two-stage d1 pipeline (F2) and a same-edge AND (F3).
module multiflop_f #(
    parameter int size = 1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [size-1:0] d1,
    input  logic [size-1:0] d2,
    output logic [size-1:0] f1_q1,
    output logic [size-1:0] f1_q2,
    output logic [size-1:0] f2_q1,
    output logic [size-1:0] f2_q2,
    output logic [size-1:0] f3_q1,
    output logic [size-1:0] f3_q2
);

    // Every output is a flop; reset forces all of them to zero immediately,
    // including F2's first stage so no stale data leaks out after release.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            f1_q1 <= '0;
            f1_q2 <= '0;
            f2_q1 <= '0;
            f2_q2 <= '0;
            f3_q1 <= '0;
            f3_q2 <= '0;
        end else begin
            f1_q1 <= d1;
            f1_q2 <= d2;
            f2_q1 <= d1;
            f2_q2 <= f2_q1;
            f3_q1 <= d1;
            // Uses the d1 sampled at this edge, not the previously held f3_q1.
            f3_q2 <= d1 & d2;
        end
    end

endmodule

// File: tb/tb_multiflop_f.sv
// Directed bench for multiflop_f: a size=4 and a size=1 instance side by side.
module tb_multiflop_f;

    logic       clk;
    logic       reset_n;
    logic [3:0] d1_4, d2_4;
    logic [3:0] f1_q1_4, f1_q2_4, f2_q1_4, f2_q2_4, f3_q1_4, f3_q2_4;
    logic       d1_1, d2_1;
    logic       f1_q1_1, f1_q2_1, f2_q1_1, f2_q2_1, f3_q1_1, f3_q2_1;
    logic [23:0] obs4;

    int n_vec;
    int n_err;

    multiflop_f #(.size(4)) u4 (
        .clk(clk), .reset_n(reset_n), .d1(d1_4), .d2(d2_4),
        .f1_q1(f1_q1_4), .f1_q2(f1_q2_4), .f2_q1(f2_q1_4),
        .f2_q2(f2_q2_4), .f3_q1(f3_q1_4), .f3_q2(f3_q2_4)
    );

    multiflop_f #(.size(1)) u1 (
        .clk(clk), .reset_n(reset_n), .d1(d1_1), .d2(d2_1),
        .f1_q1(f1_q1_1), .f1_q2(f1_q2_1), .f2_q1(f2_q1_1),
        .f2_q2(f2_q2_1), .f3_q1(f3_q1_1), .f3_q2(f3_q2_1)
    );

    assign obs4 = {f1_q1_4, f1_q2_4, f2_q1_4, f2_q2_4, f3_q1_4, f3_q2_4};

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        d1_4 = 4'hF; d2_4 = 4'hF; d1_1 = 1'b1; d2_1 = 1'b1;
        tick();
        tick();
        n_vec++;
        if (obs4 !== 24'h0) begin
            n_err++;
            $display("FAIL reset_size4: actual=%h required=%h", obs4, 24'h0);
        end
        n_vec++;
        if ({f1_q1_1, f1_q2_1, f2_q1_1, f2_q2_1, f3_q1_1, f3_q2_1} !== 6'b0) begin
            n_err++;
            $display("FAIL reset_size1: actual=%b required=000000",
                     {f1_q1_1, f1_q2_1, f2_q1_1, f2_q2_1, f3_q1_1, f3_q2_1});
        end
        d1_4 = 4'h0; d2_4 = 4'h0; d1_1 = 1'b0; d2_1 = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_basic();
        d1_4 = 4'b1010; d2_4 = 4'b0110;
        tick();
        n_vec++;
        if (obs4 !== {4'b1010, 4'b0110, 4'b1010, 4'b0000, 4'b1010, 4'b0010}) begin
            n_err++;
            $display("FAIL basic_edge1: actual=%h required=%h", obs4,
                     {4'b1010, 4'b0110, 4'b1010, 4'b0000, 4'b1010, 4'b0010});
        end
    endtask

    task automatic test_pipeline();
        tick();
        n_vec++;
        if ({f2_q1_4, f2_q2_4} !== {4'b1010, 4'b1010}) begin
            n_err++;
            $display("FAIL pipe_edge2: actual=%h required=%h", {f2_q1_4, f2_q2_4}, 8'hAA);
        end
        d1_4 = 4'b0101;
        tick();
        n_vec++;
        if (obs4 !== {4'b0101, 4'b0110, 4'b0101, 4'b1010, 4'b0101, 4'b0100}) begin
            n_err++;
            $display("FAIL pipe_edge3: actual=%h required=%h", obs4,
                     {4'b0101, 4'b0110, 4'b0101, 4'b1010, 4'b0101, 4'b0100});
        end
    endtask

    task automatic test_mid_cycle();
        logic [23:0] held;
        held = {4'b0101, 4'b0110, 4'b0101, 4'b0101, 4'b0101, 4'b0100};
        tick();
        d1_4 = 4'b1100; d2_4 = 4'b1001;
        #3;
        n_vec++;
        if (obs4 !== held) begin
            n_err++;
            $display("FAIL mid_cycle_hold: actual=%h required=%h", obs4, held);
        end
        tick();
        n_vec++;
        if (obs4 !== {4'b1100, 4'b1001, 4'b1100, 4'b0101, 4'b1100, 4'b1000}) begin
            n_err++;
            $display("FAIL mid_cycle_capture: actual=%h required=%h", obs4,
                     {4'b1100, 4'b1001, 4'b1100, 4'b0101, 4'b1100, 4'b1000});
        end
    endtask

    task automatic test_async_reset();
        #2;
        reset_n = 1'b0;
        #1;
        n_vec++;
        if (obs4 !== 24'h0) begin
            n_err++;
            $display("FAIL async_reset_now: actual=%h required=%h", obs4, 24'h0);
        end
        d1_4 = 4'b0111; d2_4 = 4'b1110;
        tick();
        n_vec++;
        if (obs4 !== 24'h0) begin
            n_err++;
            $display("FAIL reset_holds: actual=%h required=%h", obs4, 24'h0);
        end
        @(negedge clk);
        reset_n = 1'b1;
        d1_4 = 4'b1111; d2_4 = 4'b0011;
        tick();
        n_vec++;
        if (obs4 !== {4'b1111, 4'b0011, 4'b1111, 4'b0000, 4'b1111, 4'b0011}) begin
            n_err++;
            $display("FAIL post_reset_capture: actual=%h required=%h", obs4,
                     {4'b1111, 4'b0011, 4'b1111, 4'b0000, 4'b1111, 4'b0011});
        end
        tick();
        n_vec++;
        if (f2_q2_4 !== 4'b1111) begin
            n_err++;
            $display("FAIL post_reset_pipe: actual=%b required=1111", f2_q2_4);
        end
    endtask

    task automatic test_four_value();
        logic v1, v2;
        v1 = 1'bx; v2 = 1'b0;
        d1_1 = v1; d2_1 = v2;
        tick();
        n_vec++;
        if (f1_q1_1 !== v1 || f3_q2_1 !== (v1 & v2) || f3_q2_1 !== 1'b0) begin
            n_err++;
            $display("FAIL x_and_zero: actual=%b%b required=%b0", f1_q1_1, f3_q2_1, v1);
        end
        v2 = 1'b1;
        d2_1 = v2;
        tick();
        n_vec++;
        if (f3_q2_1 !== (v1 & v2) || f2_q2_1 !== v1) begin
            n_err++;
            $display("FAIL x_and_one: actual=%b%b required=%b%b",
                     f3_q2_1, f2_q2_1, v1 & v2, v1);
        end
        v1 = 1'bz; v2 = 1'bz;
        d1_1 = v1; d2_1 = v2;
        tick();
        n_vec++;
        if (f1_q1_1 !== v1 || f1_q2_1 !== v2 || f2_q1_1 !== v1 || f3_q1_1 !== v1
            || f3_q2_1 !== (v1 & v2)) begin
            n_err++;
            $display("FAIL z_capture: actual=%b%b%b%b%b required=%b%b%b%b%b",
                     f1_q1_1, f1_q2_1, f2_q1_1, f3_q1_1, f3_q2_1,
                     v1, v2, v1, v1, v1 & v2);
        end
        d1_1 = 1'b1; d2_1 = 1'b1;
        tick();
        n_vec++;
        if ({f1_q1_1, f1_q2_1, f2_q1_1, f3_q1_1, f3_q2_1} !== 5'b11111) begin
            n_err++;
            $display("FAIL size1_ones: actual=%b required=11111",
                     {f1_q1_1, f1_q2_1, f2_q1_1, f3_q1_1, f3_q2_1});
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] m1q1, m1q2, m2q1, m2q2, m3q1, m3q2;
        logic [23:0] exp_v;
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        reset_n = 1'b1;
        {m1q1, m1q2, m2q1, m2q2, m3q1, m3q2} = '0;
        for (int i = 0; i < 24; i++) begin
            d1_4 = 4'($urandom_range(0, 15));
            d2_4 = 4'($urandom_range(0, 15));
            m2q2 = m2q1;
            m2q1 = d1_4;
            m1q1 = d1_4;
            m1q2 = d2_4;
            m3q1 = d1_4;
            m3q2 = d1_4 & d2_4;
            tick();
            exp_v = {m1q1, m1q2, m2q1, m2q2, m3q1, m3q2};
            n_vec++;
            if (obs4 !== exp_v) begin
                n_err++;
                $display("FAIL random_step%0d: actual=%h required=%h", i, obs4, exp_v);
            end
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset_n = 1'b0;
        d1_4 = '0; d2_4 = '0; d1_1 = 1'b0; d2_1 = 1'b0;
        test_reset();
        test_basic();
        test_pipeline();
        test_mid_cycle();
        test_async_reset();
        test_four_value();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
